// File: rtl/lock_pkg.sv
// Shared definitions for the keypad combination lock: state encoding, digit
// width, default code digits and the one-hot -> BCD decode used by the lock
// controller and by any display logic that shows the pressed digit.
package lock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned KEY_W   = 10;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 3;

    localparam logic [DIGIT_W-1:0] CODE0_DEF = 4'd0;
    localparam logic [DIGIT_W-1:0] CODE1_DEF = 4'd9;
    localparam logic [DIGIT_W-1:0] CODE2_DEF = 4'd3;
    localparam logic [DIGIT_W-1:0] CODE3_DEF = 4'd1;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [DIGIT_W-1:0] bcd;
    } key_dec_t;

    // Exactly one set bit gives a valid digit; zero or multi-hot keys are invalid
    // and report bcd=0 so they can never alias a real digit.
    function automatic key_dec_t onehot_to_bcd(input logic [KEY_W-1:0] key);
        key_dec_t    d;
        int unsigned ones;
        d.valid = 1'b0;
        d.bcd   = '0;
        ones    = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (key[i]) begin
                ones  = ones + 1;
                d.bcd = DIGIT_W'(i);
            end
        end
        d.valid = (ones == 1);
        if (!d.valid) begin
            d.bcd = '0;
        end
        return d;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational keypad decoder: 10-line one-hot key -> {valid, bcd}.
// Ports:
//   key      in  10  one-hot key lines, key[d] = digit d
//   valid_c  out 1   exactly one key line set
//   bcd_c    out 4   index of the set line (0 when invalid)
module keypad_decode
    import lock_pkg::*;
(
    input  logic [KEY_W-1:0]   key,
    output logic               valid_c,
    output logic [DIGIT_W-1:0] bcd_c
);

    key_dec_t dec;

    always_comb begin
        dec     = onehot_to_bcd(key);
        valid_c = dec.valid;
        bcd_c   = dec.bcd;
    end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Four-digit combination lock controller. Digits arrive one per key_valid strobe,
// are compared against the stored code, and the result drives timed unlock,
// failed-attempt counting and timed lockout. One down-timer is shared by the
// entry timeout, the open window and the lockout window.
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous active-high reset
//   key         in   10  one-hot digit
//   key_valid   in   1   one-cycle strobe qualifying key
//   clear       in   1   abort entry / relock
//   unlocked    out  1   high while open
//   locked_out  out  1   high while locked out
//   digit_cnt   out  3   digits accepted in current attempt
//   fail_cnt    out  3   consecutive failed attempts
//   accept      out  1   pulse on correct code
//   reject      out  1   pulse on wrong code
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] CODE0       = CODE0_DEF,
    parameter logic [DIGIT_W-1:0] CODE1       = CODE1_DEF,
    parameter logic [DIGIT_W-1:0] CODE2       = CODE2_DEF,
    parameter logic [DIGIT_W-1:0] CODE3       = CODE3_DEF,
    parameter int unsigned        MAX_FAIL    = 3,
    parameter int unsigned        LOCKOUT_CYC = 1000,
    parameter int unsigned        OPEN_CYC    = 500,
    parameter int unsigned        TIMEOUT_CYC = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic             key_valid,
    input  logic             clear,
    output logic             unlocked,
    output logic             locked_out,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             accept,
    output logic             reject
);

    localparam int unsigned TMR_MAX = max3(LOCKOUT_CYC, OPEN_CYC, TIMEOUT_CYC);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] OPEN_LOAD    = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               match, match_nxt;
    logic [CNT_W-1:0]   digit_nxt, fail_nxt, fail_inc;
    logic               accept_nxt, reject_nxt;

    logic               key_ok_c;
    logic [DIGIT_W-1:0] key_bcd_c;
    logic [DIGIT_W-1:0] exp_digit;
    logic               digit_hit;

    keypad_decode u_decode (
        .key     (key),
        .valid_c (key_ok_c),
        .bcd_c   (key_bcd_c)
    );

    // Code digit expected at the current position of the attempt.
    always_comb begin
        exp_digit = CODE3;
        case (digit_cnt)
            3'd0:    exp_digit = CODE0;
            3'd1:    exp_digit = CODE1;
            3'd2:    exp_digit = CODE2;
            default: exp_digit = CODE3;
        endcase
    end

    // Invalid keys still advance the attempt but can never match.
    assign digit_hit = key_ok_c && (key_bcd_c == exp_digit);
    assign fail_inc  = CNT_W'(fail_cnt + 3'd1);

    // State, counters and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            match      <= 1'b0;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            accept     <= 1'b0;
            reject     <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            match      <= match_nxt;
            digit_cnt  <= digit_nxt;
            fail_cnt   <= fail_nxt;
            accept     <= accept_nxt;
            reject     <= reject_nxt;
            unlocked   <= (state_nxt == S_OPEN);
            locked_out <= (state_nxt == S_LOCKOUT);
        end
    end

    // Next-state and next-output logic; clear beats a simultaneous key.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        match_nxt  = match;
        digit_nxt  = digit_cnt;
        fail_nxt   = fail_cnt;
        accept_nxt = 1'b0;
        reject_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (key_valid && !clear) begin
                    state_nxt = S_ENTRY;
                    digit_nxt = 3'd1;
                    match_nxt = digit_hit;
                    timer_nxt = TIMEOUT_LOAD;
                end
            end

            S_ENTRY: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    digit_nxt = '0;
                    match_nxt = 1'b0;
                    timer_nxt = '0;
                end else if (key_valid) begin
                    match_nxt = match && digit_hit;
                    timer_nxt = TIMEOUT_LOAD;
                    digit_nxt = CNT_W'(digit_cnt + 3'd1);
                    if (digit_cnt == 3'd3) begin
                        state_nxt = S_CHECK;
                    end
                end else if (timer == '0) begin
                    state_nxt = S_IDLE;
                    digit_nxt = '0;
                    match_nxt = 1'b0;
                end else begin
                    timer_nxt = TMR_W'(timer - 1'b1);
                end
            end

            S_CHECK: begin
                digit_nxt = '0;
                match_nxt = 1'b0;
                if (match) begin
                    state_nxt  = S_OPEN;
                    accept_nxt = 1'b1;
                    fail_nxt   = '0;
                    timer_nxt  = OPEN_LOAD;
                end else begin
                    reject_nxt = 1'b1;
                    fail_nxt   = fail_inc;
                    if (fail_inc == CNT_W'(MAX_FAIL)) begin
                        state_nxt = S_LOCKOUT;
                        timer_nxt = LOCKOUT_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end
                end
            end

            S_OPEN: begin
                if (clear || timer == '0) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = TMR_W'(timer - 1'b1);
                end
            end

            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_nxt = S_IDLE;
                    fail_nxt  = '0;
                end else begin
                    timer_nxt = TMR_W'(timer - 1'b1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
                match_nxt = 1'b0;
                digit_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue/countdown model of the lock.
module tb_keypad_lock_ctrl;

    localparam int OPEN_N    = 5;
    localparam int LOCK_N    = 8;
    localparam int TIMEOUT_N = 6;
    localparam int MAXF      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key = '0;
    logic       key_valid = 1'b0;
    logic       clear = 1'b0;
    logic       unlocked, locked_out, accept, reject;
    logic [2:0] digit_cnt, fail_cnt;

    int checks = 0;
    int passed = 0;

    int code_d [4] = '{0, 9, 3, 1};

    // Reference model: digits entered so far, countdowns and pending verdict.
    int entered[$];
    int open_left, lock_left, fails, idle_run;
    bit judging, e_acc, e_rej;

    always #5 clk = ~clk;

    keypad_lock_ctrl #(
        .MAX_FAIL    (MAXF),
        .LOCKOUT_CYC (LOCK_N),
        .OPEN_CYC    (OPEN_N),
        .TIMEOUT_CYC (TIMEOUT_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_valid  (key_valid),
        .clear      (clear),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt),
        .accept     (accept),
        .reject     (reject)
    );

    function automatic int decode(input logic [9:0] k);
        int idx = -1;
        if ($countones(k) != 1) return -1;
        for (int i = 0; i < 10; i++) if (k[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        entered.delete();
        open_left = 0; lock_left = 0; fails = 0; idle_run = 0;
        judging = 0; e_acc = 0; e_rej = 0;
    endtask

    task automatic model_step(input logic kv, input logic [9:0] k, input logic clr);
        bit ok;
        e_acc = 0;
        e_rej = 0;
        if (judging) begin
            judging = 0;
            ok = 1;
            for (int i = 0; i < 4; i++) if (entered[i] != code_d[i]) ok = 0;
            entered.delete();
            if (ok) begin
                e_acc = 1; fails = 0; open_left = OPEN_N;
            end else begin
                e_rej = 1; fails++;
                if (fails == MAXF) lock_left = LOCK_N;
            end
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (open_left > 0) begin
            open_left = clr ? 0 : open_left - 1;
        end else if (entered.size() == 0) begin
            if (kv && !clr) begin
                entered.push_back(decode(k));
                idle_run = 0;
            end
        end else begin
            if (clr) begin
                entered.delete();
            end else if (kv) begin
                entered.push_back(decode(k));
                idle_run = 0;
                if (entered.size() == 4) judging = 1;
            end else begin
                idle_run++;
                if (idle_run == TIMEOUT_N) entered.delete();
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("unlocked",   32'(unlocked),   32'(open_left > 0));
        check("locked_out", 32'(locked_out), 32'(lock_left > 0));
        check("digit_cnt",  32'(digit_cnt),  32'(entered.size()));
        check("fail_cnt",   32'(fail_cnt),   32'(fails));
        check("accept",     32'(accept),     32'(e_acc));
        check("reject",     32'(reject),     32'(e_rej));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic step(input logic kv, input logic [9:0] k, input logic clr, input logic r);
        key_valid = kv; key = k; clear = clr; rst = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(kv, k, clr);
        #1;
        check_all();
    endtask

    task automatic press(input int d);
        logic [9:0] k;
        k = '0;
        k[d] = 1'b1;
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic code(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        logic [9:0] rk;
        model_reset();
        step(1'b0, 10'd0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b1);

        // Correct code opens for the open window.
        code(0, 9, 3, 1);
        idle(OPEN_N + 3);

        // Three wrong attempts lead to lockout; keys during lockout ignored.
        code(0, 9, 3, 2); idle(2);
        code(0, 9, 3, 2); idle(2);
        code(0, 9, 3, 2);
        idle(1);
        code(0, 9, 3, 1);
        idle(LOCK_N);

        // Entry timeout returns to idle without counting a failure.
        press(0); press(9);
        idle(TIMEOUT_N + 1);
        code(0, 9, 3, 1);
        idle(OPEN_N + 1);

        // Multi-hot first digit forces a mismatch.
        step(1'b1, 10'b0000000011, 1'b0, 1'b0);
        press(9); press(3); press(1);
        idle(2);

        // Clear together with a key aborts entry and drops the key.
        press(0); press(9);
        rk = 10'b0000001000;
        step(1'b1, rk, 1'b1, 1'b0);
        idle(1);
        code(0, 9, 3, 1);
        idle(1);
        step(1'b0, 10'd0, 1'b1, 1'b0);
        idle(2);

        // Reset during lockout and during entry.
        code(1, 1, 1, 1); idle(1);
        code(1, 1, 1, 1); idle(1);
        code(1, 1, 1, 1); idle(2);
        step(1'b0, 10'd0, 1'b0, 1'b1);
        press(0); press(9);
        step(1'b0, 10'd0, 1'b0, 1'b1);
        code(0, 9, 3, 1);
        idle(OPEN_N + 1);

        // Random traffic biased toward the correct code.
        for (int n = 0; n < 1500; n++) begin
            logic kv, clr, r;
            int   pos;
            kv  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 4);
            r   = ($urandom_range(0, 199) == 0);
            pos = entered.size();
            if (pos > 3) pos = 0;
            rk = '0;
            if ($urandom_range(0, 9) == 0) begin
                rk = 10'($urandom);
            end else if ($urandom_range(0, 9) < 6) begin
                rk[code_d[pos]] = 1'b1;
            end else begin
                rk[$urandom_range(0, 9)] = 1'b1;
            end
            step(kv, rk, clr, r);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
